// File: rtl/afifo_mem_mc_if.sv
// Bundles the write-port and read-port signals of afifo_mem_mc.
// The master side is the FIFO controller; the slave side is the memory.
interface afifo_mem_mc_if #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CHANNELS   = 2,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) ();
  logic                  WR_EN;
  logic [CH_W-1:0]       WR_CH;
  logic [ADDR_WIDTH:0]   ADDR_WR;
  logic [WIDTH-1:0]      DATA_IN;
  logic [WIDTH/8-1:0]    BYTE_EN;
  logic [CHANNELS-1:0]   FULL_FLAG;
  logic                  CLR_REQ;
  logic                  WR_ACCEPT;
  logic                  INIT_BUSY;
  logic                  R_EN;
  logic [CH_W-1:0]       R_CH;
  logic [ADDR_WIDTH:0]   ADDR_R;
  logic [CHANNELS-1:0]   EMPTY_FLAG;
  logic                  RD_READY;
  logic [WIDTH-1:0]      DATA_OUT;
  logic                  DATA_VALID;
  logic [CH_W-1:0]       RD_CH_OUT;

  modport master (
    output WR_EN, WR_CH, ADDR_WR, DATA_IN, BYTE_EN, FULL_FLAG, CLR_REQ,
    output R_EN, R_CH, ADDR_R, EMPTY_FLAG,
    input  WR_ACCEPT, INIT_BUSY, RD_READY, DATA_OUT, DATA_VALID, RD_CH_OUT
  );

  modport slave (
    input  WR_EN, WR_CH, ADDR_WR, DATA_IN, BYTE_EN, FULL_FLAG, CLR_REQ,
    input  R_EN, R_CH, ADDR_R, EMPTY_FLAG,
    output WR_ACCEPT, INIT_BUSY, RD_READY, DATA_OUT, DATA_VALID, RD_CH_OUT
  );
endinterface

// File: rtl/afifo_mem_mc.sv
// Multi-channel dual-clock FIFO storage: byte-masked writes, self-clearing
// init sweep in the write domain, pipelined reads in the read domain.
module afifo_mem_mc #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int CHANNELS   = 2,
  parameter int RD_LATENCY = 1
) (
  input logic               CLK_WRITE,
  input logic               WR_RST,
  input logic               CLK_READ,
  input logic               R_RST,
  afifo_mem_mc_if.slave     bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NB    = WIDTH / 8;
  localparam int DEPTH = CHANNELS << ADDR_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(DEPTH - 1);
  localparam logic [31:0]      CH_LIM     = 32'(CHANNELS);

  typedef enum logic {RUN = 1'b0, INIT = 1'b1} state_t;

  state_t                 state_r, state_nx_s;
  logic [IDX_W-1:0]       sweep_r, sweep_nx_s;
  logic [WIDTH-1:0]       mem [DEPTH];

  logic [CH_W+ADDR_WIDTH-1:0] wr_full_s, rd_full_s;
  logic [IDX_W-1:0]       wr_idx_s, rd_idx_s;
  logic                   wr_ch_ok_s, rd_ch_ok_s, wr_accept_s, rd_accept_s;
  logic                   rdy_meta_r, rdy_r;
  logic                   v1_r;
  logic [WIDTH-1:0]       d1_r;
  logic [CH_W-1:0]        c1_r;
  logic                   unused_ptr_msb_s;

  // Channel is the upper index field; pointer MSB is only the wrap bit.
  assign wr_full_s  = {bus.WR_CH, bus.ADDR_WR[ADDR_WIDTH-1:0]};
  assign rd_full_s  = {bus.R_CH, bus.ADDR_R[ADDR_WIDTH-1:0]};
  assign wr_idx_s   = wr_full_s[IDX_W-1:0];
  assign rd_idx_s   = rd_full_s[IDX_W-1:0];
  assign unused_ptr_msb_s = bus.ADDR_WR[ADDR_WIDTH] ^ bus.ADDR_R[ADDR_WIDTH];

  assign wr_ch_ok_s  = (32'(bus.WR_CH) < CH_LIM);
  assign rd_ch_ok_s  = (32'(bus.R_CH) < CH_LIM);
  assign wr_accept_s = bus.WR_EN & (state_r == RUN) & wr_ch_ok_s & ~bus.FULL_FLAG[bus.WR_CH];
  assign rd_accept_s = bus.R_EN & rdy_r & rd_ch_ok_s & ~bus.EMPTY_FLAG[bus.R_CH];

  assign bus.WR_ACCEPT = wr_accept_s;
  assign bus.INIT_BUSY = (state_r == INIT);
  assign bus.RD_READY  = rdy_r;

  // Write-domain FSM state and sweep counter.
  always_ff @(posedge CLK_WRITE or negedge WR_RST) begin
    if (!WR_RST) begin
      state_r <= INIT;
      sweep_r <= '0;
    end else begin
      state_r <= state_nx_s;
      sweep_r <= sweep_nx_s;
    end
  end

  // Next-state logic: sweep to the last word, then run until CLR_REQ.
  always_comb begin
    state_nx_s = state_r;
    sweep_nx_s = sweep_r;
    case (state_r)
      INIT: begin
        if (sweep_r == SWEEP_LAST) begin
          state_nx_s = RUN;
          sweep_nx_s = '0;
        end else begin
          sweep_nx_s = sweep_r + IDX_W'(1);
        end
      end
      RUN: begin
        if (bus.CLR_REQ) begin
          state_nx_s = INIT;
          sweep_nx_s = '0;
        end else begin
          sweep_nx_s = '0;
        end
      end
      default: begin
        state_nx_s = INIT;
        sweep_nx_s = '0;
      end
    endcase
  end

  // Storage write port: sweep zeroes one word per cycle, otherwise masked write.
  always_ff @(posedge CLK_WRITE) begin
    if (state_r == INIT) begin
      mem[sweep_r] <= '0;
    end else if (wr_accept_s) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.BYTE_EN[i]) begin
          mem[wr_idx_s][i*8 +: 8] <= bus.DATA_IN[i*8 +: 8];
        end
      end
    end
  end

  // Bring the write-domain ready status into the read clock.
  always_ff @(posedge CLK_READ or negedge R_RST) begin
    if (!R_RST) begin
      rdy_meta_r <= 1'b0;
      rdy_r      <= 1'b0;
    end else begin
      rdy_meta_r <= (state_r == RUN);
      rdy_r      <= rdy_meta_r;
    end
  end

  // First read stage: data and channel only move on an accepted read.
  always_ff @(posedge CLK_READ or negedge R_RST) begin
    if (!R_RST) begin
      v1_r <= 1'b0;
      d1_r <= '0;
      c1_r <= '0;
    end else begin
      v1_r <= rd_accept_s;
      if (rd_accept_s) begin
        d1_r <= mem[rd_idx_s];
        c1_r <= bus.R_CH;
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic             v2_r;
    logic [WIDTH-1:0] d2_r;
    logic [CH_W-1:0]  c2_r;

    // Second stage keeps one word per cycle flowing, so no bubbles.
    always_ff @(posedge CLK_READ or negedge R_RST) begin
      if (!R_RST) begin
        v2_r <= 1'b0;
        d2_r <= '0;
        c2_r <= '0;
      end else begin
        v2_r <= v1_r;
        if (v1_r) begin
          d2_r <= d1_r;
          c2_r <= c1_r;
        end
      end
    end

    assign bus.DATA_OUT   = d2_r;
    assign bus.DATA_VALID = v2_r;
    assign bus.RD_CH_OUT  = c2_r;
  end else begin : g_lat1
    assign bus.DATA_OUT   = d1_r;
    assign bus.DATA_VALID = v1_r;
    assign bus.RD_CH_OUT  = c1_r;
  end
endmodule

// File: tb/tb_afifo_mem_mc.sv
// Directed bench: instance A uses defaults, instance B uses WIDTH=16,
// ADDR_WIDTH=3, CHANNELS=3, RD_LATENCY=2.
module tb_afifo_mem_mc;
  logic clk_w = 1'b0;
  logic clk_r = 1'b0;
  logic wr_rst, r_rst;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk_w = ~clk_w;
  always #7 clk_r = ~clk_r;

  afifo_mem_mc_if #(.WIDTH(8),  .ADDR_WIDTH(5), .CHANNELS(2)) ia ();
  afifo_mem_mc_if #(.WIDTH(16), .ADDR_WIDTH(3), .CHANNELS(3)) ib ();

  afifo_mem_mc #(.WIDTH(8), .ADDR_WIDTH(5), .CHANNELS(2), .RD_LATENCY(1)) dut_a (
    .CLK_WRITE(clk_w), .WR_RST(wr_rst), .CLK_READ(clk_r), .R_RST(r_rst), .bus(ia));
  afifo_mem_mc #(.WIDTH(16), .ADDR_WIDTH(3), .CHANNELS(3), .RD_LATENCY(2)) dut_b (
    .CLK_WRITE(clk_w), .WR_RST(wr_rst), .CLK_READ(clk_r), .R_RST(r_rst), .bus(ib));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic ch, input logic [5:0] addr, input logic [7:0] d,
                      input logic be, output logic acc);
    @(negedge clk_w);
    ia.WR_EN = 1'b1; ia.WR_CH = ch; ia.ADDR_WR = addr; ia.DATA_IN = d; ia.BYTE_EN = be;
    #1 acc = ia.WR_ACCEPT;
    @(negedge clk_w);
    ia.WR_EN = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] ch, input logic [3:0] addr, input logic [15:0] d,
                      input logic [1:0] be, output logic acc);
    @(negedge clk_w);
    ib.WR_EN = 1'b1; ib.WR_CH = ch; ib.ADDR_WR = addr; ib.DATA_IN = d; ib.BYTE_EN = be;
    #1 acc = ib.WR_ACCEPT;
    @(negedge clk_w);
    ib.WR_EN = 1'b0;
  endtask

  task automatic rd_a(input logic ch, input logic [5:0] addr,
                      output logic [7:0] d, output logic v, output logic c);
    @(negedge clk_r);
    ia.R_EN = 1'b1; ia.R_CH = ch; ia.ADDR_R = addr;
    @(negedge clk_r);
    ia.R_EN = 1'b0;
    d = ia.DATA_OUT; v = ia.DATA_VALID; c = ia.RD_CH_OUT;
  endtask

  // Counts write-clock edges until INIT_BUSY is seen low.
  task automatic count_sweep(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk_w);
      @(negedge clk_w);
      cnt++;
    end while (ia.INIT_BUSY && cnt < 200);
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk_r);
      cnt++;
    end while (!ia.RD_READY && cnt < 20);
  endtask

  initial begin
    logic       acc, v, c, acc_seen;
    logic [7:0] d, orr;
    int         cnt, nvalid;

    wr_rst = 1'b0; r_rst = 1'b0;
    ia.WR_EN = 1'b0; ia.WR_CH = '0; ia.ADDR_WR = '0; ia.DATA_IN = '0; ia.BYTE_EN = '0;
    ia.FULL_FLAG = '0; ia.CLR_REQ = 1'b0; ia.R_EN = 1'b0; ia.R_CH = '0; ia.ADDR_R = '0;
    ia.EMPTY_FLAG = '0;
    ib.WR_EN = 1'b0; ib.WR_CH = '0; ib.ADDR_WR = '0; ib.DATA_IN = '0; ib.BYTE_EN = '0;
    ib.FULL_FLAG = '0; ib.CLR_REQ = 1'b0; ib.R_EN = 1'b0; ib.R_CH = '0; ib.ADDR_R = '0;
    ib.EMPTY_FLAG = '0;

    repeat (3) @(negedge clk_w);
    chk("rst_init_busy", 32'(ia.INIT_BUSY), 32'd1);
    chk("rst_rd_ready", 32'(ia.RD_READY), 32'd0);
    chk("rst_data_out", 32'(ia.DATA_OUT), 32'd0);
    chk("rst_data_valid", 32'(ia.DATA_VALID), 32'd0);
    chk("rst_rd_ch_out", 32'(ia.RD_CH_OUT), 32'd0);

    @(negedge clk_w);
    wr_rst = 1'b1; r_rst = 1'b1;
    count_sweep(cnt);
    chk("init_sweep_cycles", 32'(cnt), 32'd64);
    wait_ready(cnt);
    chk("rd_ready_lag_2to3", 32'(cnt >= 2 && cnt <= 3), 32'd1);
    chk("b_init_done", 32'(ib.INIT_BUSY), 32'd0);
    chk("b_rd_ready", 32'(ib.RD_READY), 32'd1);

    orr = 8'h00; nvalid = 0;
    for (int i = 0; i < 64; i++) begin
      logic [6:0] iv;
      iv = 7'(i);
      rd_a(iv[5], {1'b0, iv[4:0]}, d, v, c);
      orr = orr | d;
      nvalid += int'(v);
    end
    chk("init_all_zero", 32'(orr), 32'd0);
    chk("init_all_valid", 32'(nvalid), 32'd64);

    // Instance B: byte-masked 16-bit merge, latency 2, channel range.
    wr_b(2'd2, 4'b0011, 16'h1234, 2'b11, acc);
    chk("b_wr1_accept", 32'(acc), 32'd1);
    wr_b(2'd2, 4'b1011, 16'hABCD, 2'b10, acc);
    chk("b_wr2_accept", 32'(acc), 32'd1);
    @(negedge clk_r);
    ib.R_EN = 1'b1; ib.R_CH = 2'd2; ib.ADDR_R = 4'b0011;
    @(negedge clk_r);
    ib.R_EN = 1'b0;
    chk("b_lat2_not_early", 32'(ib.DATA_VALID), 32'd0);
    @(negedge clk_r);
    chk("b_lat2_valid", 32'(ib.DATA_VALID), 32'd1);
    chk("b_byte_merge", 32'(ib.DATA_OUT), 32'hAB34);
    chk("b_rd_ch_out", 32'(ib.RD_CH_OUT), 32'd2);
    wr_b(2'd3, 4'd1, 16'hDEAD, 2'b11, acc);
    chk("b_bad_channel_reject", 32'(acc), 32'd0);
    wr_b(2'd0, 4'd0, 16'h1111, 2'b11, acc);
    wr_b(2'd0, 4'd1, 16'h2222, 2'b11, acc);
    @(negedge clk_r);
    ib.R_EN = 1'b1; ib.R_CH = 2'd0; ib.ADDR_R = 4'd0;
    @(negedge clk_r);
    ib.ADDR_R = 4'd1;
    @(negedge clk_r);
    ib.R_EN = 1'b0;
    chk("b_b2b_first_valid", 32'(ib.DATA_VALID), 32'd1);
    chk("b_b2b_first_data", 32'(ib.DATA_OUT), 32'h1111);
    @(negedge clk_r);
    chk("b_b2b_second_valid", 32'(ib.DATA_VALID), 32'd1);
    chk("b_b2b_second_data", 32'(ib.DATA_OUT), 32'h2222);
    @(negedge clk_r);
    chk("b_idle_valid_low", 32'(ib.DATA_VALID), 32'd0);
    chk("b_idle_data_held", 32'(ib.DATA_OUT), 32'h2222);
    ib.R_EN = 1'b1; ib.R_CH = 2'd3; ib.ADDR_R = 4'd0;
    @(negedge clk_r);
    ib.R_EN = 1'b0;
    repeat (2) @(negedge clk_r);
    chk("b_bad_channel_read", 32'(ib.DATA_VALID), 32'd0);

    // Instance A: basic write/read, masks, flags, pointer MSB.
    wr_a(1'b1, 6'b100011, 8'hA5, 1'b1, acc);
    chk("a_wr_accept", 32'(acc), 32'd1);
    rd_a(1'b1, 6'b000011, d, v, c);
    chk("a_rd_data", 32'(d), 32'hA5);
    chk("a_rd_valid", 32'(v), 32'd1);
    chk("a_rd_ch", 32'(c), 32'd1);
    @(negedge clk_r);
    chk("a_valid_one_cycle", 32'(ia.DATA_VALID), 32'd0);
    chk("a_data_held", 32'(ia.DATA_OUT), 32'hA5);
    wr_a(1'b1, 6'b000011, 8'hFF, 1'b0, acc);
    rd_a(1'b1, 6'b000011, d, v, c);
    chk("a_be0_no_update", 32'(d), 32'hA5);
    ia.FULL_FLAG = 2'b01;
    wr_a(1'b0, 6'd3, 8'h3C, 1'b1, acc);
    chk("a_full_reject", 32'(acc), 32'd0);
    wr_a(1'b1, 6'd4, 8'h5A, 1'b1, acc);
    chk("a_other_ch_accept", 32'(acc), 32'd1);
    ia.FULL_FLAG = 2'b00;
    rd_a(1'b0, 6'd3, d, v, c);
    chk("a_full_unchanged", 32'(d), 32'h00);
    rd_a(1'b1, 6'd4, d, v, c);
    chk("a_ch1_addr4", 32'(d), 32'h5A);
    ia.EMPTY_FLAG = 2'b10;
    rd_a(1'b1, 6'd3, d, v, c);
    chk("a_empty_no_valid", 32'(v), 32'd0);
    chk("a_empty_data_held", 32'(d), 32'h5A);
    ia.EMPTY_FLAG = 2'b00;
    wr_a(1'b0, 6'd31, 8'h77, 1'b1, acc);
    rd_a(1'b0, 6'b111111, d, v, c);
    chk("a_top_addr_msb_ignored", 32'(d), 32'h77);

    // CLR_REQ sweep with WR_EN held and a second CLR_REQ mid-sweep.
    @(negedge clk_w);
    ia.CLR_REQ = 1'b1; ia.WR_CH = 1'b1; ia.ADDR_WR = 6'd5; ia.DATA_IN = 8'hEE; ia.BYTE_EN = 1'b1;
    cnt = 0; acc_seen = 1'b0;
    do begin
      @(posedge clk_w);
      @(negedge clk_w);
      cnt++;
      if (ia.INIT_BUSY) begin
        #1 acc_seen = acc_seen | ia.WR_ACCEPT;
        ia.WR_EN = 1'b1;
        ia.CLR_REQ = (cnt == 10);
      end else begin
        ia.WR_EN = 1'b0;
        ia.CLR_REQ = 1'b0;
      end
    end while (ia.INIT_BUSY && cnt < 200);
    ia.WR_EN = 1'b0;
    // One edge to enter INIT plus 64 sweep edges.
    chk("clr_sweep_cycles", 32'(cnt), 32'd65);
    chk("clr_no_accept_in_init", 32'(acc_seen), 32'd0);
    wait_ready(cnt);
    chk("clr_ready_again", 32'(ia.RD_READY), 32'd1);
    orr = 8'h00;
    rd_a(1'b1, 6'd3, d, v, c); orr = orr | d;
    rd_a(1'b1, 6'd4, d, v, c); orr = orr | d;
    rd_a(1'b0, 6'd31, d, v, c); orr = orr | d;
    rd_a(1'b1, 6'd5, d, v, c); orr = orr | d;
    chk("clr_cleared_words", 32'(orr), 32'd0);

    // WR_RST partway through a sweep restarts it; read side keeps its data.
    wr_a(1'b0, 6'd2, 8'h99, 1'b1, acc);
    rd_a(1'b0, 6'd2, d, v, c);
    chk("pre_wrrst_read", 32'(d), 32'h99);
    @(negedge clk_w);
    ia.CLR_REQ = 1'b1;
    @(negedge clk_w);
    ia.CLR_REQ = 1'b0;
    repeat (20) @(negedge clk_w);
    wr_rst = 1'b0;
    repeat (3) @(negedge clk_w);
    chk("wrrst_init_busy", 32'(ia.INIT_BUSY), 32'd1);
    @(negedge clk_r);
    chk("wrrst_dout_kept", 32'(ia.DATA_OUT), 32'h99);
    chk("wrrst_valid_low", 32'(ia.DATA_VALID), 32'd0);
    @(negedge clk_w);
    wr_rst = 1'b1;
    count_sweep(cnt);
    chk("wrrst_full_restart", 32'(cnt), 32'd64);
    wait_ready(cnt);
    rd_a(1'b0, 6'd2, d, v, c);
    chk("wrrst_word_cleared", 32'(d), 32'h00);

    // R_RST clears the read-side outputs asynchronously.
    wr_a(1'b1, 6'd7, 8'hC3, 1'b1, acc);
    rd_a(1'b1, 6'd7, d, v, c);
    chk("pre_rrst_read", 32'(d), 32'hC3);
    @(negedge clk_r);
    r_rst = 1'b0;
    #1;
    chk("rrst_dout", 32'(ia.DATA_OUT), 32'd0);
    chk("rrst_ch", 32'(ia.RD_CH_OUT), 32'd0);
    chk("rrst_ready", 32'(ia.RD_READY), 32'd0);
    chk("rrst_write_side_run", 32'(ia.INIT_BUSY), 32'd0);
    @(negedge clk_r);
    r_rst = 1'b1;
    wait_ready(cnt);
    rd_a(1'b1, 6'd7, d, v, c);
    chk("post_rrst_mem_kept", 32'(d), 32'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/afifo_mem_mc.md
AFIFO_MEM_MC -- requirements
Module: afifo_mem_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; legal values are multiples of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, per-channel address bits; each channel holds 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter CHANNELS, default 2, number of independent memory banks; legal range 1..16; CH_W = max(1, clog2(CHANNELS)).
REQ-004 SHALL have parameter RD_LATENCY, default 1, accepted-read-to-data latency in CLK_READ cycles; legal values 1 and 2.
REQ-005 SHALL have ports:
- CLK_WRITE  in  1  write clock.
- WR_RST  in  1  reset for the write domain, asynchronous, active-low.
- CLK_READ  in  1  read clock.
- R_RST  in  1  read-domain reset, asynchronous, active-low.
- WR_EN  in  1  write request.
- WR_CH  in  CH_W  write channel.
- ADDR_WR  in  ADDR_WIDTH+1  write pointer; MSB is the wrap bit and is ignored for addressing.
- DATA_IN  in  WIDTH  write data.
- BYTE_EN  in  WIDTH/8  per-byte write mask.
- FULL_FLAG  in  CHANNELS  per-channel full.
- CLR_REQ  in  1  single-cycle re-initialise request, write domain.
- WR_ACCEPT  out  1  write committed this cycle, combinational.
- INIT_BUSY  out  1  initialisation sweep active.
- R_EN  in  1  read request.
- R_CH  in  CH_W  read channel.
- ADDR_R  in  ADDR_WIDTH+1  read pointer; MSB ignored.
- EMPTY_FLAG  in  CHANNELS  per-channel empty.
- RD_READY  out  1  memory initialised, read-domain view.
- DATA_OUT  out  WIDTH  read data.
- DATA_VALID  out  1  one-cycle strobe: DATA_OUT is new.
- RD_CH_OUT  out  CH_W  channel of the word on DATA_OUT.

Function
REQ-006 SHALL store CHANNELS*2**ADDR_WIDTH words; word index = WR_CH*2**ADDR_WIDTH + ADDR_WR[ADDR_WIDTH-1:0]. The read index SHALL be formed the same way from R_CH and ADDR_R.
REQ-007 SHALL implement a write-domain FSM with states INIT and RUN.
REQ-008 In INIT, the FSM SHALL write all-zero to one word per CLK_WRITE cycle, ascending from index 0. It SHALL go to RUN after the last index, so the sweep takes exactly CHANNELS*2**ADDR_WIDTH cycles.
REQ-009 INIT_BUSY SHALL be 1 in INIT and 0 in RUN.
REQ-010 In RUN, a CLR_REQ=1 cycle SHALL move the FSM to INIT with the sweep counter at 0. A CLR_REQ asserted while in INIT SHALL be ignored.
REQ-011 WR_ACCEPT SHALL equal WR_EN & RUN & !FULL_FLAG[WR_CH] & (WR_CH < CHANNELS). A write with WR_ACCEPT=0 SHALL leave memory unchanged.
REQ-012 On an accepted write, only byte lanes with BYTE_EN[i]=1 SHALL update; other lanes keep their old value.
REQ-013 RD_READY SHALL be the inverse of INIT_BUSY passed through a 2-flop synchroniser clocked by CLK_READ.
REQ-014 A read SHALL be accepted when R_EN & RD_READY & !EMPTY_FLAG[R_CH] & (R_CH < CHANNELS).
REQ-015 On an accepted read, the addressed word SHALL appear on DATA_OUT with DATA_VALID=1 exactly RD_LATENCY CLK_READ edges later. RD_CH_OUT SHALL carry R_CH with the same alignment.
REQ-016 DATA_OUT and RD_CH_OUT SHALL hold their value between accepted reads. DATA_VALID SHALL be 0 in any cycle without new data.
REQ-017 With RD_LATENCY=2, back-to-back accepted reads SHALL produce back-to-back DATA_VALID pulses, with no bubble.
REQ-018 Reads SHALL NOT modify memory contents; there is no clear-on-read.
REQ-019 A read and a write to the same index in overlapping cycles SHALL return either the old or the new word; no other value is permitted.
REQ-020 Reads accepted while RD_READY=1 but the FSM has already re-entered INIT (synchroniser lag, at most 2 CLK_READ cycles) SHALL return either zero or the prior content.

Reset
REQ-021 WR_RST low SHALL force the FSM to INIT, set the sweep counter to 0 and set INIT_BUSY=1. Memory content is not reset directly; the sweep clears it after release.
REQ-022 R_RST low SHALL clear DATA_OUT=0, DATA_VALID=0, RD_CH_OUT=0, the read pipeline and the RD_READY synchroniser.
REQ-023 WR_RST asserted mid-sweep or mid-write SHALL restart the sweep from index 0 after release.
REQ-024 The two resets SHALL be independent; either may be asserted alone without corrupting the other domain's registers.

Verification
REQ-025 Release both resets with defaults -> INIT_BUSY=1 for 64 CLK_WRITE cycles, then 0. RD_READY rises 2-3 CLK_READ cycles later. Every word reads 0x00.
REQ-026 Write ch1 addr 6'b100011, data 0xA5, BYTE_EN=1, then read ch1 ADDR_R=6'b000011 -> DATA_OUT=0xA5 with DATA_VALID high at edge 1 (RD_LATENCY=1) or edge 2 (RD_LATENCY=2), and RD_CH_OUT=1.
REQ-027 WIDTH=16: write 0x1234, then 0xABCD with BYTE_EN=2'b10 to the same address -> read returns 0xAB34.
REQ-028 Write with FULL_FLAG[0]=1 on ch0, or with WR_CH=3 when CHANNELS=3 -> WR_ACCEPT=0 and content unchanged. A read with EMPTY_FLAG set -> no DATA_VALID and DATA_OUT held.
REQ-029 Fill data, pulse CLR_REQ, keep WR_EN high during the sweep -> WR_ACCEPT=0 throughout. After INIT_BUSY falls, all words read 0.
REQ-030 Assert WR_RST at sweep index 20, release -> sweep restarts at 0 and lasts the full 64 cycles. The read-side DATA_OUT is unaffected until R_RST is asserted.
